data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache that answers the pipelined datapath's memory-stage requests. It returns read data and drives the `Mem_Stall` freeze signal. It refills 4-word lines from a slower backing memory over a ready-based handshake. It sits between the datapath's M stage and main memory.

## Interface
Parameters:
- `LINES`, 32: number of cache lines; power of 2, ≥2.
- `IDX_W`, 5: log2(`LINES`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MemReadM`  in  1  load request from the M stage.
- `MemWriteM`  in  1  store request from the M stage.
- `ALUoutM`  in  32  byte address.
- `RD2_Reg_File_aft_muxM`  in  32  store data.
- `Mem_RDM`  out  32  load data.
- `Mem_Stall`  out  1  freezes all pipeline registers while high.
- `mem_req`  out  1  backing-memory request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  32  word-aligned backing-memory address (bits [1:0] = 0).
- `mem_wdata`  out  32  backing-memory write data.
- `mem_rdata`  in  32  backing-memory read data; valid when `mem_ready` = 1.
- `mem_ready`  in  1  backing memory accepts or completes the current beat at this edge.

## Operation
- Address split:
  - offset = `ALUoutM[3:2]`
  - index = `ALUoutM[IDX_W+3:4]`
  - tag = `ALUoutM[31:IDX_W+4]`
  - `ALUoutM[1:0]` is ignored.
- Storage per line: valid bit, tag, 4×32-bit data words.
- hit = `valid[index]` AND (`tag_array[index]` == tag).
- The datapath holds the request inputs stable while `Mem_Stall` = 1.
- If `MemReadM` and `MemWriteM` are both high, the request is treated as a write.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Read hit: `Mem_RDM` = stored word, combinationally. Stay in IDLE.
  - Read miss: clear beat counter, go to REFILL.
  - Write, hit: the addressed word is updated with the store data at this edge. Go to WRITE.
  - Write, miss: cache unchanged. Go to WRITE.
- REFILL:
  - Outputs: `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, beat, 2'b00}.
  - On each edge with `mem_ready` = 1: `mem_rdata` is written into word[beat], beat increments (2-bit, wraps).
  - On the beat-3 accept: set `valid[index]`, write `tag_array[index]`, go to IDLE. The held request now hits.
  - A refill overwrites the line; no writeback is needed (write-through).
- WRITE:
  - Outputs: `mem_req` = 1, `mem_we` = 1, `mem_addr` = {`ALUoutM[31:2]`, 2'b00}, `mem_wdata` = store data.
  - On `mem_ready` = 1: go to DONE.
- DONE: `Mem_Stall` = 0, so the pipeline advances past the store. The request is ignored. Go to IDLE.
- Outputs are combinational from state and inputs:
  - `Mem_Stall` = (IDLE AND ((read AND NOT hit) OR write)) OR REFILL OR WRITE.
  - `mem_req` = REFILL OR WRITE.
  - `mem_we` = WRITE.
  - `Mem_RDM` = selected word when IDLE AND read AND hit; otherwise 32'h0.
  - `mem_addr` and `mem_wdata` = 0 when `mem_req` = 0.

## Timing
- Reset (`rst` = 0, asynchronous):
  - state → IDLE, beat → 0, all valid bits → 0.
  - `mem_req`, `mem_we`, `Mem_Stall` (no request) and `Mem_RDM` read 0.
  - Tag and data arrays are not reset.
- Read hit: 0 stall cycles; data is available in the same cycle.
- Read miss with zero-wait memory (`mem_ready` held 1): 5 stall cycles (1 IDLE + 4 REFILL). The 6th cycle hits with `Mem_Stall` = 0.
- Each `mem_ready` = 0 cycle during REFILL or WRITE adds one stall cycle.
- Store: 2 stall cycles minimum (IDLE + WRITE), then 1 non-stall DONE cycle.
- `mem_req` and the address stay stable until the beat is accepted by `mem_ready`.
- Reset mid-REFILL or mid-WRITE: the transaction is abandoned. `mem_req` drops immediately and the partially filled line stays invalid.

## Test plan
- Reset, then read `0x0000_0040` with the backing memory returning 0x11,0x22,0x33,0x44 for words `0x40`..`0x4C`, `mem_ready` = 1 → `mem_addr` sequence 0x40,0x44,0x48,0x4C; `Mem_Stall` high for 5 cycles; then `Mem_RDM` = 0x11 with `Mem_Stall` = 0.
- After the above, read `0x0000_0048` → `Mem_RDM` = 0x33 in the same cycle, `Mem_Stall` = 0, no `mem_req`.
- Store 0xDEAD_BEEF to `0x0000_0044` (hit) → one write beat at addr 0x44 with `mem_we` = 1; `Mem_Stall` 1,1,0; a later read of `0x44` hits and returns 0xDEAD_BEEF.
- Store to `0x0000_0400` (miss) → write beat issued; a later read of `0x400` misses and refills.
- Read `0x0000_0240` (same index 4, different tag) after the `0x40` fill → refill from 0x240..0x24C; a later read of `0x40` misses again.
- Hold `mem_ready` = 0 for 3 cycles on beat 1 → stall extends by 3 cycles and `mem_addr` holds 0x44. Assert `rst` = 0 during beat 2 → `mem_req` = 0 at once; after release, read `0x40` misses.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache for
// the M stage. Each line holds a valid bit, a tag and four 32-bit words.
// Read misses refill the whole line from backing memory, one word per beat.
// Every store is written through to backing memory as a single beat.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   MemReadM, MemWriteM      load / store request (write wins if both high)
//   ALUoutM                  byte address of the request
//   RD2_Reg_File_aft_muxM    store data
//   Mem_RDM                  load data (valid on an IDLE read hit, else 0)
//   Mem_Stall                freezes the pipeline while high
//   mem_req/we/addr/wdata    backing-memory beat request
//   mem_rdata, mem_ready     backing-memory response / beat accept
module data_cache #(
  parameter int LINES = 32,
  parameter int IDX_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] RD2_Reg_File_aft_muxM,
  output logic [31:0] Mem_RDM,
  output logic        Mem_Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [1:0]         beat_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][4];

  logic [1:0]         offset;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               wr_req;
  logic               rd_req;
  logic               unused_byte_sel;

  assign offset = ALUoutM[3:2];
  assign index  = ALUoutM[IDX_W+3:4];
  assign tag    = ALUoutM[31:IDX_W+4];
  assign hit    = valid_q[index] && (tag_q[index] == tag);
  assign wr_req = MemWriteM;
  assign rd_req = MemReadM & ~MemWriteM;

  // Byte lane bits play no part in a word-granular cache.
  assign unused_byte_sel = ^ALUoutM[1:0];

  always_comb begin
    Mem_RDM   = 32'h0;
    Mem_Stall = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        Mem_Stall = wr_req | (rd_req & ~hit);
        if (rd_req && hit) Mem_RDM = data_q[index][offset];
      end
      S_REFILL: begin
        Mem_Stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {ALUoutM[31:4], beat_q, 2'b00};
      end
      S_WRITE: begin
        Mem_Stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ALUoutM[31:2], 2'b00};
        mem_wdata = RD2_Reg_File_aft_muxM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_req) begin
            state_q <= S_WRITE;
          end else if (rd_req && !hit) begin
            beat_q  <= 2'd0;
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              valid_q[index] <= 1'b1;
              state_q        <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; a line is only trusted once its
  // valid bit is set on the final refill beat, so partial fills are harmless.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && wr_req && hit) begin
      data_q[index][offset] <= RD2_Reg_File_aft_muxM;
    end
    if (state_q == S_REFILL && mem_ready) begin
      data_q[index][beat_q] <= mem_rdata;
      if (beat_q == 2'd3) tag_q[index] <= tag;
    end
  end

endmodule
